opb_register_bank_ppc2simulink: RTL and testbench
=================================================

OPB_REGISTER_BANK_PPC2SIMULINK -- requirements
Module: opb_register_bank_ppc2simulink

Interface
REQ-001 The block SHALL have these parameters:
- C_BASEADDR, 32'h01028000, first byte address of the block.
- C_HIGHADDR, 32'h010280FF, last byte address of the block.
- C_NUM_REGS, 4, number of 32-bit software registers (1..16).
- C_SHADOW, 0, mode select: 0 = direct, 1 = staged with atomic commit.
- C_INIT, 32'h00000000, reset value of every register.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- OPB_Clk, in, 1, the single clock.
- OPB_Rst_n, in, 1, reset; asynchronous, active-low.
- OPB_ABus, in, [0:31], byte address.
- OPB_BE, in, [0:3], byte enables; BE[0] qualifies DBus[0:7].
- OPB_DBus, in, [0:31], write data.
- OPB_RNW, in, 1, 1 = read, 0 = write.
- OPB_select, in, 1, transfer request.
- OPB_seqAddr, in, 1, ignored.
- Sl_DBus, out, [0:31], read data.
- Sl_xferAck, out, 1, transfer acknowledge.
- Sl_errAck, out, 1, tied 0.
- Sl_retry, out, 1, tied 0.
- Sl_toutSup, out, 1, tied 0.
- user_data_out, out, [32*C_NUM_REGS-1:0], register k on bits [32k+31:32k].
- user_update, out, [C_NUM_REGS-1:0], per-register one-cycle update strobe.

REQ-003 Bit mapping: DBus[i] SHALL map to register bit 31-i, so DBus[31] is the register LSB.

Function
REQ-004 Hit definition: hit = OPB_select AND C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Let offset = OPB_ABus - C_BASEADDR. Word index w = offset[7:2]. offset[1:0] is ignored.

REQ-005 Address map:
- w < C_NUM_REGS: register w.
- w == C_NUM_REGS: CTRL.
- Any other in-range w: unmapped.

REQ-006 Handshake FSM states and transitions:
- IDLE -> ACK on hit.
- ACK -> HOLD unconditionally.
- HOLD -> IDLE unconditionally; select is ignored while in HOLD.

REQ-007 Sl_xferAck SHALL be 1 exactly during ACK, i.e. one cycle, starting the cycle after the hit was sampled.

REQ-008 ABus, BE, DBus and RNW SHALL be captured on the IDLE->ACK edge. Later changes to these inputs SHALL have no effect on the transfer.

REQ-009 Sl_DBus SHALL carry read data only during ACK when the captured RNW = 1, and SHALL be 0 in every other cycle (OPB wired-OR).

REQ-010 Read data:
- Register w: returns its software view (the staging value when C_SHADOW = 1, the output value when C_SHADOW = 0).
- CTRL: returns {16'h0, commit_count[15:0]}.
- Unmapped: returns 0.

REQ-011 Writes to register w SHALL take effect on the ACK->HOLD edge. Only bytes with the captured BE bit set are updated; other bytes keep their value.

REQ-012 Direct mode (C_SHADOW = 0), write to register w:
- user_data_out word w updates on the ACK->HOLD edge.
- user_update[w] = 1 during the following (HOLD) cycle only.

REQ-013 Shadow mode (C_SHADOW = 1), write to register w: only the staging value changes; user_data_out and user_update are unchanged.

REQ-014 Commit: a CTRL write with DBus[31] = 1 and BE[3] = 1, in shadow mode, on the ACK->HOLD edge SHALL:
- copy all staging values to user_data_out simultaneously;
- drive user_update = all ones for the HOLD cycle;
- increment commit_count, which wraps 16'hFFFF -> 0.

REQ-015 In direct mode a CTRL write SHALL have no effect and commit_count SHALL stay 0.

REQ-016 Writes to unmapped addresses SHALL be acknowledged and discarded.

REQ-017 Accesses outside [C_BASEADDR, C_HIGHADDR] SHALL produce no acknowledge and no state change.

REQ-018 A hit arriving while the FSM is in ACK or HOLD SHALL NOT be acknowledged. If select is still asserted when the FSM returns to IDLE, it is a new transfer.

REQ-019 Write-to-output latency SHALL be 2 cycles after the hit cycle in direct mode; after the CTRL-write hit cycle in shadow mode the latency SHALL also be 2 cycles.

Reset
REQ-020 While OPB_Rst_n = 0, asynchronously:
- FSM = IDLE;
- Sl_xferAck = 0 and Sl_DBus = 0;
- all staging and output registers = C_INIT;
- user_update = 0;
- commit_count = 0.

REQ-021 Reset asserted during ACK SHALL abort the transfer: no write is applied and no strobe is produced.

REQ-022 After OPB_Rst_n rises, the first hit SHALL be accepted on the first rising edge of OPB_Clk.

Verification
REQ-023 Direct write and readback: C_SHADOW = 0; write 0x12345678 with BE = 1111 to base+0x4. Required:
- Sl_xferAck for one cycle at t+1;
- user_data_out[63:32] = 0x12345678 and user_update = 0010 at t+2;
- read of base+0x4 returns 0x12345678.

REQ-024 Byte enables: register 0 holds 0xAABBCCDD; write 0x11223344 with BE = 0101. Required: register 0 = 0xAA22CC44.

REQ-025 Shadow commit: C_SHADOW = 1, C_NUM_REGS = 4. Write 1, 2, 3 and 4 to registers 0-3. Required:
- user_data_out unchanged after the register writes;
- after writing 0x1 to base+0x10, all four words update in the same cycle with user_update = 1111;
- a CTRL read returns 0x00000001.

REQ-026 Address response: read of base+0x20 returns 0 with one acknowledge. A transfer at C_HIGHADDR+1 produces no acknowledge within 8 cycles. Select held high for 6 cycles produces acknowledges spaced 3 cycles apart.

REQ-027 Reset mid-transfer: assert OPB_Rst_n = 0 during the ACK cycle of a write of 0xFFFFFFFF to register 0. Required: Sl_xferAck drops immediately, and register 0 = C_INIT after reset.

REQ-028 commit_count wrap: preload 0xFFFF commits, then commit once more. Required: CTRL reads 0x00000000.

Source files
------------

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing C_NUM_REGS software registers to fabric, written either directly or staged then committed atomically.
// Acks one cycle after the hit, then a fixed turnaround cycle (no wait states, never retries); outputs move 2 cycles after the hit.
module opb_register_bank_ppc2simulink #(
   parameter logic [31:0] C_BASEADDR = 32'h01028000,
   parameter logic [31:0] C_HIGHADDR = 32'h010280FF,
   parameter int          C_NUM_REGS = 4,
   parameter int          C_SHADOW   = 0,
   parameter logic [31:0] C_INIT     = 32'h00000000
) (
   input  logic                     OPB_Clk,
   input  logic                     OPB_Rst_n,
   input  logic [0:31]              OPB_ABus,
   input  logic [0:3]               OPB_BE,
   input  logic [0:31]              OPB_DBus,
   input  logic                     OPB_RNW,
   input  logic                     OPB_select,
   input  logic                     OPB_seqAddr,
   output logic [0:31]              Sl_DBus,
   output logic                     Sl_xferAck,
   output logic                     Sl_errAck,
   output logic                     Sl_retry,
   output logic                     Sl_toutSup,
   output logic [32*C_NUM_REGS-1:0] user_data_out,
   output logic [C_NUM_REGS-1:0]    user_update
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_HOLD} state_t;

   typedef struct packed {
      logic [5:0]  widx;
      logic [3:0]  be;
      logic [31:0] dat;
      logic        rnw;
   } xfer_t;

   state_t                r_state;
   state_t                w_state_nxt;
   xfer_t                 r_xfer;
   logic [31:0]           r_out   [C_NUM_REGS];
   logic [31:0]           r_stage [C_NUM_REGS];
   logic [C_NUM_REGS-1:0] r_update;
   logic [15:0]           r_commit_cnt;

   logic [31:0]           w_abus;
   logic [31:0]           w_dbus;
   logic [3:0]            w_be;
   logic [31:0]           w_offset;
   logic                  w_hit;
   logic                  w_wr;
   logic                  w_commit;
   logic [31:0]           w_rdata;
   logic                  w_unused;

   // Ascending OPB vectors land MSB-first, so DBus[31] becomes bit 0 and BE[3] qualifies byte 0.
   assign w_abus   = OPB_ABus;
   assign w_dbus   = OPB_DBus;
   assign w_be     = OPB_BE;
   assign w_hit    = OPB_select && (w_abus >= C_BASEADDR) && (w_abus <= C_HIGHADDR);
   assign w_offset = w_abus - C_BASEADDR;
   assign w_unused = OPB_seqAddr ^ (^w_offset[31:8]) ^ (^w_offset[1:0]);

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_hit) w_state_nxt = ST_ACK;
         ST_ACK:  w_state_nxt = ST_HOLD;
         ST_HOLD: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_xfer <= '0;
      end else if (r_state == ST_IDLE && w_hit) begin
         r_xfer <= '{widx: w_offset[7:2], be: w_be, dat: w_dbus, rnw: OPB_RNW};
      end
   end

   assign w_wr     = (r_state == ST_ACK) && !r_xfer.rnw;
   assign w_commit = w_wr && (C_SHADOW != 0) && (r_xfer.widx == 6'(C_NUM_REGS))
                     && r_xfer.dat[0] && r_xfer.be[0];

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         for (int k = 0; k < C_NUM_REGS; k++) begin
            r_out[k]   <= C_INIT;
            r_stage[k] <= C_INIT;
         end
         r_update     <= '0;
         r_commit_cnt <= '0;
      end else begin
         r_update <= '0;
         if (w_wr) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
               if (r_xfer.widx == 6'(k)) begin
                  if (C_SHADOW != 0) begin
                     r_stage[k] <= merge_bytes(r_stage[k], r_xfer.dat, r_xfer.be);
                  end else begin
                     r_out[k]    <= merge_bytes(r_out[k], r_xfer.dat, r_xfer.be);
                     r_update[k] <= 1'b1;
                  end
               end
            end
         end
         // Commit publishes every staged word on the same edge so fabric never sees a partial update.
         if (w_commit) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
               r_out[k] <= r_stage[k];
            end
            r_update     <= '1;
            r_commit_cnt <= r_commit_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      for (int k = 0; k < C_NUM_REGS; k++) begin
         if (r_xfer.widx == 6'(k)) begin
            w_rdata = (C_SHADOW != 0) ? r_stage[k] : r_out[k];
         end
      end
      if (r_xfer.widx == 6'(C_NUM_REGS)) begin
         w_rdata = {16'h0000, r_commit_cnt};
      end
   end

   // Read data is zero outside the ack cycle so the shared OPB data bus can be wired-OR.
   assign Sl_DBus    = (r_state == ST_ACK && r_xfer.rnw) ? w_rdata : 32'h0;
   assign Sl_xferAck = (r_state == ST_ACK);
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;
   assign user_update = r_update;

   for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
      assign user_data_out[32*g +: 32] = r_out[g];
   end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Bench for the OPB register bank: one direct-mode and one shadow-mode instance on a shared bus.
module tb_opb_register_bank_ppc2simulink;

   localparam logic [31:0] BASE = 32'h01028000;
   localparam logic [31:0] HIGH = 32'h010280FF;

   logic         clk;
   logic         rst_n;
   logic [0:31]  abus;
   logic [0:3]   be_v;
   logic [0:31]  dbus;
   logic         rnw_v;
   logic         sel_d, sel_s;
   logic         seq_addr;

   logic [0:31]  dbus_d, dbus_s;
   logic         ack_d, ack_s, err_d, err_s, rty_d, rty_s, tout_d, tout_s;
   logic [127:0] out_d, out_s;
   logic [3:0]   upd_d, upd_s;

   int           n_chk;
   int           n_fail;

   logic [31:0]  rd_dat;
   int           ack_lat;
   logic [127:0] ack_out, hold_out;
   logic [3:0]   hold_upd, idle_upd;
   logic         hold_ack;
   logic [31:0]  hold_dbus;

   // Reference state: direct register values, shadow staging/output values, commit counter.
   logic [31:0]  m_dir [4];
   logic [31:0]  m_stg [4];
   logic [31:0]  m_out [4];
   logic [15:0]  m_cnt;

   opb_register_bank_ppc2simulink #(.C_SHADOW(0)) dut_d (
      .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be_v), .OPB_DBus(dbus),
      .OPB_RNW(rnw_v), .OPB_select(sel_d), .OPB_seqAddr(seq_addr), .Sl_DBus(dbus_d),
      .Sl_xferAck(ack_d), .Sl_errAck(err_d), .Sl_retry(rty_d), .Sl_toutSup(tout_d),
      .user_data_out(out_d), .user_update(upd_d));

   opb_register_bank_ppc2simulink #(.C_SHADOW(1)) dut_s (
      .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be_v), .OPB_DBus(dbus),
      .OPB_RNW(rnw_v), .OPB_select(sel_s), .OPB_seqAddr(seq_addr), .Sl_DBus(dbus_s),
      .Sl_xferAck(ack_s), .Sl_errAck(err_s), .Sl_retry(rty_s), .Sl_toutSup(tout_s),
      .user_data_out(out_s), .user_update(upd_s));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] apply_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

   function automatic logic [127:0] pack4(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
      return {w3, w2, w1, w0};
   endfunction

   // Runs one bus transfer starting at the current falling edge; inputs are scrambled right
   // after the ack so any late dependence on them shows up in the results.
   task automatic xfer(input bit sh, input logic [31:0] addr, input bit rnw,
                       input logic [3:0] be, input logic [31:0] dat);
      ack_lat = -1;
      rd_dat  = 32'hDEADBEEF;
      abus = addr; be_v = be; dbus = dat; rnw_v = rnw;
      if (sh) sel_s = 1'b1; else sel_d = 1'b1;
      for (int i = 1; i <= 8 && ack_lat < 0; i++) begin
         @(negedge clk);
         if ((sh ? ack_s : ack_d) === 1'b1) begin
            ack_lat = i;
            rd_dat  = sh ? dbus_s : dbus_d;
            ack_out = sh ? out_s : out_d;
            sel_d = 1'b0; sel_s = 1'b0;
            abus = $urandom; dbus = $urandom; be_v = 4'($urandom); rnw_v = 1'($urandom);
         end
      end
      sel_d = 1'b0; sel_s = 1'b0;
      @(negedge clk);
      hold_ack  = sh ? ack_s : ack_d;
      hold_upd  = sh ? upd_s : upd_d;
      hold_out  = sh ? out_s : out_d;
      hold_dbus = sh ? dbus_s : dbus_d;
      @(negedge clk);
      idle_upd  = sh ? upd_s : upd_d;
   endtask

   initial begin
      int acks[$];
      n_chk = 0; n_fail = 0;
      rst_n = 1'b0; sel_d = 1'b0; sel_s = 1'b0; seq_addr = 1'b0;
      abus = '0; be_v = '0; dbus = '0; rnw_v = 1'b0;
      m_cnt = '0;
      for (int k = 0; k < 4; k++) begin m_dir[k] = '0; m_stg[k] = '0; m_out[k] = '0; end

      // Reset state.
      #12;
      chk("rst_ack_d", ack_d, 0);
      chk("rst_ack_s", ack_s, 0);
      chk("rst_dbus_d", dbus_d, 0);
      chk("rst_out_d", out_d, 0);
      chk("rst_out_s", out_s, 0);
      chk("rst_upd", {upd_d, upd_s}, 0);
      chk("tied_low", {err_d, rty_d, tout_d, err_s, rty_s, tout_s}, 0);

      // Direct write right at reset release: ack at t+1, output and strobe at t+2.
      @(negedge clk);
      rst_n = 1'b1;
      xfer(0, BASE + 32'h4, 0, 4'hF, 32'h12345678);
      m_dir[1] = 32'h12345678;
      chk("dir_wr_ack_lat", ack_lat, 1);
      chk("dir_wr_ack_one_cycle", hold_ack, 0);
      chk("dir_wr_out_at_ack", ack_out, 0);
      chk("dir_wr_out_word1", hold_out[63:32], 32'h12345678);
      chk("dir_wr_upd", hold_upd, 4'b0010);
      chk("dir_wr_upd_gone", idle_upd, 0);
      xfer(0, BASE + 32'h4, 1, 4'hF, 32'h0);
      chk("dir_rd_word1", rd_dat, 32'h12345678);
      chk("dir_rd_dbus_hold", hold_dbus, 0);

      // Byte enables.
      xfer(0, BASE, 0, 4'hF, 32'hAABBCCDD);
      xfer(0, BASE, 0, 4'b0101, 32'h11223344);
      m_dir[0] = 32'hAA22CC44;
      chk("be_out_word0", hold_out[31:0], 32'hAA22CC44);
      xfer(0, BASE, 1, 4'hF, 32'h0);
      chk("be_rd_word0", rd_dat, 32'hAA22CC44);

      // CTRL in direct mode does nothing; unmapped is acked and discarded.
      xfer(0, BASE + 32'h10, 0, 4'hF, 32'h1);
      chk("dir_ctrl_upd", hold_upd, 0);
      chk("dir_ctrl_out", hold_out, pack4(m_dir[0], m_dir[1], m_dir[2], m_dir[3]));
      xfer(0, BASE + 32'h10, 1, 4'hF, 32'h0);
      chk("dir_ctrl_rd", rd_dat, 0);
      xfer(0, BASE + 32'h20, 1, 4'hF, 32'h0);
      chk("unmap_rd_lat", ack_lat, 1);
      chk("unmap_rd_dat", rd_dat, 0);
      xfer(0, BASE + 32'h20, 0, 4'hF, 32'hFFFFFFFF);
      chk("unmap_wr_lat", ack_lat, 1);
      chk("unmap_wr_upd", hold_upd, 0);
      chk("unmap_wr_out", hold_out, pack4(m_dir[0], m_dir[1], m_dir[2], m_dir[3]));

      // Out of range on either side.
      xfer(0, HIGH + 32'h1, 0, 4'hF, 32'hFFFFFFFF);
      chk("oor_high_noack", ack_lat, -1);
      chk("oor_high_out", hold_out, pack4(m_dir[0], m_dir[1], m_dir[2], m_dir[3]));
      xfer(0, BASE - 32'h4, 0, 4'hF, 32'hFFFFFFFF);
      chk("oor_low_noack", ack_lat, -1);
      chk("oor_low_upd", hold_upd, 0);

      // Select held for 6 cycles.
      abus = BASE; rnw_v = 1'b1; be_v = 4'hF; sel_d = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (ack_d === 1'b1) acks.push_back(c);
         if (c == 6) sel_d = 1'b0;
      end
      chk("held_sel_count", acks.size(), 2);
      if (acks.size() == 2) begin
         chk("held_sel_first", acks[0], 1);
         chk("held_sel_spacing", acks[1] - acks[0], 3);
      end

      // Random direct-mode traffic against the model.
      for (int t = 0; t < 24; t++) begin
         int          w;
         bit          r;
         logic [3:0]  b;
         logic [31:0] d, exp_rd;
         logic [3:0]  exp_upd;
         w = $urandom_range(0, 5);
         if (w == 5) w = $urandom_range(5, 63);
         r = 1'($urandom); b = 4'($urandom); d = $urandom;
         xfer(0, BASE + 32'(w) * 4 + 32'($urandom_range(0, 3)), r, b, d);
         exp_upd = '0;
         exp_rd  = (w < 4) ? m_dir[w] : 32'h0;
         if (!r && w < 4) begin
            m_dir[w] = apply_be(m_dir[w], d, b);
            exp_upd  = 4'(1 << w);
         end
         chk("rnd_dir_lat", ack_lat, 1);
         if (r) chk("rnd_dir_rd", rd_dat, exp_rd);
         else   chk("rnd_dir_upd", hold_upd, exp_upd);
         chk("rnd_dir_out", hold_out, pack4(m_dir[0], m_dir[1], m_dir[2], m_dir[3]));
      end

      // Shadow: staged writes are invisible until the commit.
      for (int k = 0; k < 4; k++) begin
         xfer(1, BASE + 32'(k) * 4, 0, 4'hF, 32'(k + 1));
         m_stg[k] = 32'(k + 1);
         chk("shd_stage_out", hold_out, 0);
         chk("shd_stage_upd", hold_upd, 0);
      end
      xfer(1, BASE + 32'h8, 1, 4'hF, 32'h0);
      chk("shd_rd_stage", rd_dat, 32'h3);
      xfer(1, BASE + 32'h10, 0, 4'hF, 32'h1);
      for (int k = 0; k < 4; k++) m_out[k] = m_stg[k];
      m_cnt++;
      chk("commit_out_at_ack", ack_out, 0);
      chk("commit_out", hold_out, pack4(32'h1, 32'h2, 32'h3, 32'h4));
      chk("commit_upd", hold_upd, 4'hF);
      chk("commit_upd_gone", idle_upd, 0);
      xfer(1, BASE + 32'h10, 1, 4'hF, 32'h0);
      chk("commit_cnt_rd", rd_dat, 32'h1);
      // No commit without DBus[31] or without BE[3].
      xfer(1, BASE + 32'h10, 0, 4'b1110, 32'hFFFFFFFF);
      chk("nocommit_be", hold_upd, 0);
      xfer(1, BASE + 32'h10, 0, 4'hF, 32'hFFFFFFFE);
      chk("nocommit_bit", hold_upd, 0);

      // Random shadow traffic including commits.
      for (int t = 0; t < 24; t++) begin
         int          w;
         bit          r;
         logic [3:0]  b;
         logic [31:0] d, exp_rd;
         logic [3:0]  exp_upd;
         w = $urandom_range(0, 5);
         r = ($urandom_range(0, 3) == 0);
         b = 4'($urandom); d = $urandom;
         if (w == 4 && $urandom_range(0, 1) == 1) begin b[0] = 1'b1; d[0] = 1'b1; end
         xfer(1, BASE + 32'(w) * 4, r, b, d);
         exp_upd = '0;
         exp_rd  = (w < 4) ? m_stg[w] : (w == 4) ? {16'h0, m_cnt} : 32'h0;
         if (!r && w < 4) m_stg[w] = apply_be(m_stg[w], d, b);
         if (!r && w == 4 && b[0] && d[0]) begin
            for (int k = 0; k < 4; k++) m_out[k] = m_stg[k];
            m_cnt++;
            exp_upd = 4'hF;
         end
         if (r) chk("rnd_shd_rd", rd_dat, exp_rd);
         else   chk("rnd_shd_upd", hold_upd, exp_upd);
         chk("rnd_shd_out", hold_out, pack4(m_out[0], m_out[1], m_out[2], m_out[3]));
      end

      // Commit counter wrap from a preloaded 0xFFFF.
      force dut_s.r_commit_cnt = 16'hFFFF;
      @(negedge clk);
      release dut_s.r_commit_cnt;
      m_cnt = 16'hFFFF;
      xfer(1, BASE + 32'h10, 1, 4'hF, 32'h0);
      chk("wrap_preload_rd", rd_dat, 32'h0000FFFF);
      xfer(1, BASE + 32'h10, 0, 4'h1, 32'h1);
      m_cnt++;
      chk("wrap_commit_upd", hold_upd, 4'hF);
      xfer(1, BASE + 32'h10, 1, 4'hF, 32'h0);
      chk("wrap_rd", rd_dat, {16'h0, m_cnt});

      // Reset during the ack of a write aborts it.
      abus = BASE; be_v = 4'hF; dbus = 32'hFFFFFFFF; rnw_v = 1'b0; sel_d = 1'b1;
      @(negedge clk);
      chk("abort_ack_seen", ack_d, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_ack_drop", ack_d, 0);
      chk("abort_out", out_d, 0);
      chk("abort_upd", upd_d, 0);
      sel_d = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_upd_after", upd_d, 0);
      xfer(0, BASE, 1, 4'hF, 32'h0);
      chk("abort_rd_word0", rd_dat, 32'h0);
      chk("abort_out_after", hold_out, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule
